bcd_score_converter: RTL and testbench

//   Sequential binary-to-BCD converter (shift-and-add-3) for the game score.

---
 rtl/bcd_pkg.sv | 33 +++
 rtl/bcd_digit_adj.sv | 24 ++
 rtl/bcd_score_converter.sv | 180 ++++++++++++++++++
 tb/tb_bcd_score_converter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// ============================================================================
//  Module   : bcd_pkg
//  Purpose  : Shared types and constants for the binary-to-BCD score
//             converter: FSM state encoding, nibble width and a constant
//             function giving the largest value representable in N BCD digits.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Largest value that fits in 'digits' decimal digits (10^digits - 1).
  function automatic int unsigned bcd_max(input int unsigned digits);
    int unsigned v;
    v = 1;
    for (int unsigned k = 0; k < digits; k++) begin
      v = v * 10;
    end
    return v - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// ============================================================================
//  Module   : bcd_digit_adj
//  Purpose  : Combinational shift-and-add-3 correction for one BCD nibble.
//             Adds 3 when the nibble is 5 or more so the following left shift
//             carries correctly into the next decimal digit.
//  Ports    : i_digit  in  4  BCD nibble before correction
//             o_digit  out 4  corrected nibble
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_digit,
  output logic [NIBBLE_W-1:0] o_digit
);

  // Inputs never exceed 9 during a valid conversion, so the sum stays in 4 bits.
  assign o_digit = (i_digit >= NIBBLE_W'(5)) ? (i_digit + NIBBLE_W'(3)) : i_digit;

endmodule

`default_nettype wire

// File: rtl/bcd_score_converter.sv
// ============================================================================
//  Module   : bcd_score_converter
//  Purpose  : Sequential binary-to-BCD converter (shift-and-add-3) for the
//             game score. Re-converts whenever binary_in differs from the last
//             converted sample, holding the previous result stable meanwhile.
//  Ports    : clk        in   1         system clock
//             reset_n    in   1         asynchronous active-low reset
//             binary_in  in   BIN_W     unsigned score, sampled in IDLE/LOAD
//             bcd_out    out  4*DIGITS  packed BCD, digit 0 in [3:0]
//             bcd_valid  out  1         one-cycle pulse when bcd_out updates
//             busy       out  1         high in LOAD/SHIFT/DONE
//             overflow   out  1         last sample exceeded 10^DIGITS-1
//             blank_n    out  DIGITS    leading-zero mask
//  Config   : BCD_BLANK_EN  enables the registered leading-zero mask; when
//             undefined blank_n is tied to all ones.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_score_converter
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [BIN_W-1:0]           binary_in,
  output logic [NIBBLE_W*DIGITS-1:0] bcd_out,
  output logic                       bcd_valid,
  output logic                       busy,
  output logic                       overflow,
  output logic [DIGITS-1:0]          blank_n
);

  localparam int          BCD_W   = NIBBLE_W * DIGITS;
  localparam int          SR_W    = BCD_W + BIN_W;
  localparam int          CNT_W   = $clog2(BIN_W + 1);
  localparam int unsigned MAX_VAL = bcd_max(DIGITS);

  state_t             r_state;
  state_t             w_state_next;
  logic [BIN_W-1:0]   r_last;
  logic [SR_W-1:0]    r_sr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_pend;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_ovf;

  logic               w_over;
  logic [BIN_W-1:0]   w_work;
  logic [SR_W-1:0]    w_sr_adj;
  logic [SR_W-1:0]    w_sr_next;
  logic [BCD_W-1:0]   w_bcd_next;
  logic               w_last_shift;
  logic               w_busy;
  logic               w_valid;

  // Saturation: compare in 64 bits so any BIN_W up to 32 is safe.
  assign w_over = 64'(binary_in) > 64'(MAX_VAL);
  assign w_work = w_over ? BIN_W'(MAX_VAL) : binary_in;

  // Per-nibble +3 correction on the BCD field, binary field passes through.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_sr[BIN_W + NIBBLE_W*gi +: NIBBLE_W]),
      .o_digit (w_sr_adj[BIN_W + NIBBLE_W*gi +: NIBBLE_W])
    );
  end
  assign w_sr_adj[BIN_W-1:0] = r_sr[BIN_W-1:0];

  assign w_sr_next    = {w_sr_adj[SR_W-2:0], 1'b0};
  assign w_bcd_next   = w_sr_next[SR_W-1 -: BCD_W];
  assign w_last_shift = (r_state == SHIFT) && (r_cnt == CNT_W'(1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_valid      = 1'b0;
    case (r_state)
      IDLE: begin
        if (binary_in != r_last) begin
          w_state_next = LOAD;
        end
      end
      LOAD: begin
        w_busy       = 1'b1;
        w_state_next = SHIFT;
      end
      SHIFT: begin
        w_busy = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_busy       = 1'b1;
        w_valid      = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ----------------------------------------------------------- datapath
  // The result registers are written on the final shift edge so that the
  // new value is already visible during DONE, aligned with bcd_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last     <= '0;
      r_sr       <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          r_last     <= binary_in;
          r_sr       <= {{BCD_W{1'b0}}, w_work};
          r_cnt      <= CNT_W'(BIN_W);
          r_ovf_pend <= w_over;
        end
        SHIFT: begin
          r_sr  <= w_sr_next;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last_shift) begin
            r_bcd <= w_bcd_next;
            r_ovf <= r_ovf_pend;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bcd_out   = r_bcd;
  assign overflow  = r_ovf;
  assign busy      = w_busy;
  assign bcd_valid = w_valid;

  // ------------------------------------------------------ blanking mask
`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank_next;

  // Digit 0 always lit; digit i lit if it or any higher digit is nonzero.
  assign w_blank_next[0] = 1'b1;
  for (genvar gb = 1; gb < DIGITS; gb++) begin : g_blank
    assign w_blank_next[gb] = |w_bcd_next[BCD_W-1:NIBBLE_W*gb];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blank <= DIGITS'(1);
    end else if (w_last_shift) begin
      r_blank <= w_blank_next;
    end
  end

  assign blank_n = r_blank;
`else
  assign blank_n = '1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_score_converter.sv
// ============================================================================
//  Module   : tb_bcd_score_converter
//  Purpose  : Self-checking bench for bcd_score_converter using directed
//             corner cases plus randomized scores against a decimal model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_score_converter;

  logic        clk;
  logic        reset_n;
  logic [15:0] binary_in;
  logic [15:0] bcd_out;
  logic        bcd_valid;
  logic        busy;
  logic        overflow;
  logic [3:0]  blank_n;

  int n_checks = 0;
  int n_errors = 0;
  int m_last   = 0;

  bcd_score_converter #(.BIN_W(16), .DIGITS(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .binary_in (binary_in),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .busy      (busy),
    .overflow  (overflow),
    .blank_n   (blank_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Decimal digits of the saturated score, digit 0 least significant.
  function automatic logic [15:0] model_bcd(input int v);
    int          s;
    logic [15:0] r;
    s = (v > 9999) ? 9999 : v;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(s % 10);
      s = s / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] model_blank(input int v);
    logic [3:0] b;
`ifdef BCD_BLANK_EN
    int s;
    int n;
    s = (v > 9999) ? 9999 : v;
    n = 1;
    while (s >= 10) begin
      s = s / 10;
      n++;
    end
    for (int i = 0; i < 4; i++) b[i] = (i < n);
`else
    b = 4'hF;
    if (v < 0) b = 4'h0;
`endif
    return b;
  endfunction

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy !== 1'b0 && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_valid(input int budget, output int lat);
    int c;
    lat = -1;
    c   = 0;
    while (lat < 0 && c < budget) begin
      @(negedge clk);
      c++;
      if (bcd_valid === 1'b1) lat = c;
    end
  endtask

  // Drive a new score while idle and check the resulting pulse.
  task automatic apply(input int v, input string tag);
    int lat;
    int seen;
    wait_idle();
    binary_in = 16'(v);
    if (v == m_last) begin
      seen = 0;
      repeat (25) begin
        @(negedge clk);
        if (bcd_valid === 1'b1) seen++;
      end
      check({tag, "_nopulse"}, 32'(seen), 32'd0);
    end else begin
      wait_valid(40, lat);
      check({tag, "_lat"}, 32'(lat), 32'd18);
      check({tag, "_bcd"}, 32'(bcd_out), 32'(model_bcd(v)));
      check({tag, "_ovf"}, 32'(overflow), 32'(v > 9999));
      check({tag, "_blank"}, 32'(blank_n), 32'(model_blank(v)));
      m_last = v;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt_v;
    int cnt_b;
    int c;
    int pulses;
    int lat;
    logic [15:0] first_v;
    logic [15:0] second_v;
    int v;

    // Reset with zero input: nothing should convert.
    reset_n   = 1'b0;
    binary_in = 16'd0;
    repeat (5) @(negedge clk);
    check("rst_bcd", 32'(bcd_out), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_blank", 32'(blank_n), 32'(model_blank(0)));
    reset_n = 1'b1;
    cnt_v = 0;
    cnt_b = 0;
    repeat (100) begin
      @(negedge clk);
      if (bcd_valid === 1'b1) cnt_v++;
      if (busy === 1'b1) cnt_b++;
    end
    check("idle0_valid", 32'(cnt_v), 32'd0);
    check("idle0_busy", 32'(cnt_b), 32'd0);
    check("idle0_bcd", 32'(bcd_out), 32'h0);

    // Directed values and saturation boundaries.
    apply(1234, "d1234");
    apply(65535, "d65535");
    apply(10000, "d10000");
    apply(9999, "d9999");
    apply(9999, "d9999_again");

    // Input change mid-conversion.
    wait_idle();
    binary_in = 16'd42;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (busy !== 1'b1 && c < 10);
    check("mid_busy_rise", 32'(busy), 32'd1);
    repeat (5) @(negedge clk);
    binary_in = 16'd7;
    pulses   = 0;
    first_v  = 16'hFFFF;
    second_v = 16'hFFFF;
    repeat (80) begin
      @(negedge clk);
      if (bcd_valid === 1'b1) begin
        if (pulses == 0) first_v = bcd_out;
        if (pulses == 1) second_v = bcd_out;
        pulses++;
      end
    end
    check("mid_pulses", 32'(pulses), 32'd2);
    check("mid_first", 32'(first_v), 32'(model_bcd(42)));
    check("mid_second", 32'(second_v), 32'(model_bcd(7)));
    m_last = 7;

    // Reset mid-conversion of 500.
    wait_idle();
    binary_in = 16'd500;
    repeat (8) @(negedge clk);
    check("rstmid_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rstmid_bcd", 32'(bcd_out), 32'h0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_valid", 32'(bcd_valid), 32'd0);
    check("rstmid_ovf", 32'(overflow), 32'd0);
    check("rstmid_blank", 32'(blank_n), 32'(model_blank(0)));
    cnt_v = 0;
    repeat (4) begin
      @(negedge clk);
      if (bcd_valid === 1'b1) cnt_v++;
    end
    check("rstmid_nopulse", 32'(cnt_v), 32'd0);
    reset_n = 1'b1;
    m_last  = 0;
    wait_valid(40, lat);
    check("rstmid_lat", 32'(lat), 32'd18);
    check("rstmid_500", 32'(bcd_out), 32'(model_bcd(500)));
    check("rstmid_500_ovf", 32'(overflow), 32'd0);
    m_last = 500;

    // Leading-zero mask cases.
    apply(7, "b7");
    apply(305, "b305");
    apply(0, "b0");

    // Randomized scores biased toward interesting ranges.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       v = int'($urandom_range(0, 65535));
        1:       v = int'($urandom_range(0, 99));
        2:       v = int'($urandom_range(9990, 10010));
        default: v = int'($urandom_range(0, 9999));
      endcase
      apply(v, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
